// File: rtl/imm_encoder.sv
// Packs opcode, register fields and a 32-bit immediate into a RISC-V instruction word.
// Define IMM_ENCODER_LI_EXPAND_EN to split out-of-range ADDI into a LUI+ADDI pair.
module imm_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  ImmSrc,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        range_err
);

  typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_e;

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_J = 3'b011;
  localparam logic [2:0] FMT_U = 3'b100;

  localparam logic [6:0]  OP_IMM = 7'b0010011;
  localparam logic [6:0]  OP_LUI = 7'b0110111;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic [31:0] word2_q, word2_d;
  logic        pending_q, pending_d;

  logic        accept, fire;
  logic        fits12, fits13, fits21, is_li;
  logic [19:0] hi20;
  logic [31:0] enc_word, enc_word2;
  logic        enc_err, enc_pending;

  assign accept = in_valid && in_ready;
  assign fire   = out_valid && out_ready;

  // An immediate fits N signed bits when every bit from N-1 upward equals the sign.
  assign fits12 = (&imm[31:11]) || (~|imm[31:11]);
  assign fits13 = (&imm[31:12]) || (~|imm[31:12]);
  assign fits21 = (&imm[31:20]) || (~|imm[31:20]);

  // Rounding carry so that LUI hi20 plus the sign-extended low 12 bits rebuilds imm.
  assign hi20 = imm[31:12] + {19'd0, imm[11]};

`ifdef IMM_ENCODER_LI_EXPAND_EN
  assign is_li = (ImmSrc == FMT_I) && (opcode == OP_IMM) && (funct3 == 3'b000) && !fits12;
`else
  assign is_li = 1'b0;
`endif

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    enc_word    = NOP;
    enc_err     = 1'b1;
    enc_word2   = '0;
    enc_pending = 1'b0;
    case (ImmSrc)
      FMT_I: begin
        if (is_li) begin
          enc_word    = {hi20, rd, OP_LUI};
          enc_err     = 1'b0;
          enc_word2   = {imm[11:0], rd, 3'b000, rd, OP_IMM};
          enc_pending = |imm[11:0];
        end else begin
          enc_word = {imm[11:0], rs1, funct3, rd, opcode};
          enc_err  = !fits12;
        end
      end
      FMT_S: begin
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_err  = !fits12;
      end
      FMT_B: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_err  = !fits13 || imm[0];
      end
      FMT_J: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_err  = !fits21 || imm[0];
      end
      FMT_U: begin
        enc_word = {imm[31:12], rd, opcode};
        enc_err  = |imm[11:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EMIT1;
      EMIT1:   if (fire)   state_d = pending_q ? EMIT2 : IDLE;
      EMIT2:   if (fire)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q != IDLE);
  end

  // The encoded word is captured at accept, so the outputs depend only on registers.
  always_comb begin
    instr_d   = instr_q;
    err_d     = err_q;
    word2_d   = word2_q;
    pending_d = pending_q;
    if (accept) begin
      instr_d   = enc_word;
      err_d     = enc_err;
      word2_d   = enc_word2;
      pending_d = enc_pending;
    end else if ((state_q == EMIT1) && fire && pending_q) begin
      instr_d   = word2_q;
      err_d     = 1'b0;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: holding registers are reset too, so reset visibly clears the output word and any pending pair.
    if (reset) begin
      instr_q   <= '0;
      err_q     <= 1'b0;
      word2_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      err_q     <= err_d;
      word2_q   <= word2_d;
      pending_q <= pending_d;
    end
  end

  assign out_instr = instr_q;
  assign range_err = err_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed cases plus randomized requests against
// an arithmetic reference model; honours IMM_ENCODER_LI_EXPAND_EN like the design.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ImmSrc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        range_err;

  int n_pass   = 0;
  int n_checks = 0;

  imm_encoder dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .ImmSrc(ImmSrc), .opcode(opcode), .funct3(funct3),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .range_err(range_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
  endtask

  // Immediate reconstruction, as the decoder-side extend unit does it.
  function automatic logic [31:0] extend(input logic [31:0] i, input logic [2:0] src);
    case (src)
      3'd0:    return {{20{i[31]}}, i[31:20]};
      3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd4:    return {i[31:12], 12'b0};
      default: return 32'h0;
    endcase
  endfunction

  // Reference model: fields placed by shift/mask arithmetic, ranges from signed value.
  function automatic void model(input logic [2:0] src, input logic [6:0] op, input logic [2:0] f3,
                                input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                                input logic [31:0] im, output int n, output logic [31:0] w0,
                                output logic [31:0] w1, output logic e, output bit li);
    longint v;
    logic [31:0] o, f, dd, r1, r2;
    v  = longint'($signed(im));
    o  = 32'(op);
    f  = 32'(f3) << 12;
    dd = 32'(d) << 7;
    r1 = 32'(s1) << 15;
    r2 = 32'(s2) << 20;
    n = 1; w1 = '0; e = 1'b0; li = 1'b0;
    case (src)
      3'd0: begin
        w0 = (im << 20) | r1 | f | dd | o;
        e  = (v < -2048) || (v > 2047);
      end
      3'd1: begin
        w0 = (((im >> 5) & 32'h7F) << 25) | r2 | r1 | f | ((im & 32'h1F) << 7) | o;
        e  = (v < -2048) || (v > 2047);
      end
      3'd2: begin
        w0 = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | r2 | r1 | f
           | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | o;
        e  = (v < -4096) || (v > 4095) || ((im & 32'h1) != 0);
      end
      3'd3: begin
        w0 = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
           | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | dd | o;
        e  = (v < -1048576) || (v > 1048575) || ((im & 32'h1) != 0);
      end
      3'd4: begin
        w0 = (im & 32'hFFFF_F000) | dd | o;
        e  = (im & 32'hFFF) != 0;
      end
      default: begin
        w0 = 32'h0000_0013;
        e  = 1'b1;
      end
    endcase
`ifdef IMM_ENCODER_LI_EXPAND_EN
    if (src == 3'd0 && op == 7'h13 && f3 == 3'd0 && e) begin
      longint lo, hi;
      lo = longint'((im & 32'hFFF) ^ 32'h800) - 2048;
      hi = v - lo;
      li = 1'b1;
      w0 = 32'(hi) | dd | 32'h37;
      w1 = (im << 20) | (32'(d) << 15) | dd | 32'h13;
      n  = (lo != 0) ? 2 : 1;
      e  = 1'b0;
    end
`endif
  endfunction

  // Issues one request and checks every emitted word; stall holds out_ready low on word 1.
  task automatic run_req(input string tag, input logic [2:0] src, input logic [6:0] op,
                         input logic [2:0] f3, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [31:0] im, input int n,
                         input logic [31:0] w0, input logic [31:0] w1, input logic e,
                         input int stall, output logic [31:0] got0, output logic [31:0] got1);
    int guard;
    ImmSrc = src; opcode = op; funct3 = f3; rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    guard = 0;
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    check($sformatf("%s.in_ready_wait", tag), 32'(guard < 20), 32'd1);
    step();
    in_valid = 1'b0;
    imm    = $urandom;
    ImmSrc = 3'($urandom);
    got0 = '0;
    got1 = '0;
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s.w%0d.out_valid", tag, k), 32'(out_valid), 32'd1);
      check($sformatf("%s.w%0d.in_ready", tag, k), 32'(in_ready), 32'd0);
      check($sformatf("%s.w%0d.out_instr", tag, k), out_instr, (k == 0) ? w0 : w1);
      check($sformatf("%s.w%0d.range_err", tag, k), 32'(range_err), (k == 0) ? 32'(e) : 32'd0);
      if (k == 0) got0 = out_instr;
      else        got1 = out_instr;
      if (k == 0) begin
        for (int s = 0; s < stall; s++) begin
          step();
          check($sformatf("%s.stall%0d.out_valid", tag, s), 32'(out_valid), 32'd1);
          check($sformatf("%s.stall%0d.in_ready", tag, s), 32'(in_ready), 32'd0);
          check($sformatf("%s.stall%0d.out_instr", tag, s), out_instr, w0);
          check($sformatf("%s.stall%0d.range_err", tag, s), 32'(range_err), 32'(e));
        end
      end
      out_ready = 1'b1;
      step();
    end
    check($sformatf("%s.done.out_valid", tag), 32'(out_valid), 32'd0);
    check($sformatf("%s.done.in_ready", tag), 32'(in_ready), 32'd1);
  endtask

  logic [2:0]  r_src;
  logic [6:0]  r_op;
  logic [2:0]  r_f3;
  logic [4:0]  r_rd, r_rs1, r_rs2;
  logic [31:0] r_imm, x;
  int          m_n;
  logic [31:0] m_w0, m_w1, g0, g1, rebuilt;
  logic        m_e;
  bit          m_li;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ImmSrc = '0; opcode = '0; funct3 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    step();
    step();
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.out_instr", out_instr, 32'h0);
    check("reset.range_err", 32'(range_err), 32'd0);
    reset = 1'b0;
    step();

    run_req("addi_m1", 3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF,
            1, 32'hFFF0_0093, 32'h0, 1'b0, 0, g0, g1);
    run_req("lui_ok", 3'd4, 7'h37, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0010_0000,
            1, 32'h0010_0037, 32'h0, 1'b0, 0, g0, g1);
    run_req("lui_err", 3'd4, 7'h37, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0010_0001,
            1, 32'h0010_0037, 32'h0, 1'b1, 0, g0, g1);
    run_req("beq_stall", 3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC,
            1, 32'hFE20_8EE3, 32'h0, 1'b0, 3, g0, g1);
`ifdef IMM_ENCODER_LI_EXPAND_EN
    run_req("li_pair", 3'd0, 7'h13, 3'd0, 5'd5, 5'd5, 5'd0, 32'h1234_5FFF,
            2, 32'h1234_62B7, 32'hFFF2_8293, 1'b0, 0, g0, g1);
    run_req("li_lui_only", 3'd0, 7'h13, 3'd0, 5'd3, 5'd3, 5'd0, 32'h0000_5000,
            1, 32'h0000_51B7, 32'h0, 1'b0, 0, g0, g1);
`else
    run_req("li_trunc", 3'd0, 7'h13, 3'd0, 5'd5, 5'd5, 5'd0, 32'h1234_5FFF,
            1, 32'hFFF2_8293, 32'h0, 1'b1, 0, g0, g1);
    run_req("li_trunc0", 3'd0, 7'h13, 3'd0, 5'd3, 5'd3, 5'd0, 32'h0000_5000,
            1, 32'h0001_8193, 32'h0, 1'b1, 0, g0, g1);
`endif
    run_req("illegal", 3'd7, 7'h33, 3'd5, 5'd9, 5'd10, 5'd11, 32'h0000_0004,
            1, 32'h0000_0013, 32'h0, 1'b1, 1, g0, g1);

    // Boundary immediates, expected words from the model.
    model(3'd0, 7'h13, 3'd0, 5'd2, 5'd3, 5'd0, 32'h0000_07FF, m_n, m_w0, m_w1, m_e, m_li);
    run_req("i_max", 3'd0, 7'h03, 3'd2, 5'd2, 5'd3, 5'd0, 32'h0000_07FF, 1, m_w0 & 32'hFFFF_8F80 | 32'h2003, m_w1, 1'b0, 0, g0, g1);
    model(3'd0, 7'h03, 3'd2, 5'd2, 5'd3, 5'd0, 32'h0000_0800, m_n, m_w0, m_w1, m_e, m_li);
    run_req("i_over", 3'd0, 7'h03, 3'd2, 5'd2, 5'd3, 5'd0, 32'h0000_0800, m_n, m_w0, m_w1, m_e, 0, g0, g1);
    model(3'd1, 7'h23, 3'd2, 5'd0, 5'd4, 5'd6, 32'hFFFF_F800, m_n, m_w0, m_w1, m_e, m_li);
    run_req("s_min", 3'd1, 7'h23, 3'd2, 5'd0, 5'd4, 5'd6, 32'hFFFF_F800, m_n, m_w0, m_w1, m_e, 0, g0, g1);
    model(3'd2, 7'h63, 3'd1, 5'd0, 5'd7, 5'd8, 32'h0000_0FFE, m_n, m_w0, m_w1, m_e, m_li);
    run_req("b_max", 3'd2, 7'h63, 3'd1, 5'd0, 5'd7, 5'd8, 32'h0000_0FFE, m_n, m_w0, m_w1, m_e, 0, g0, g1);
    model(3'd2, 7'h63, 3'd1, 5'd0, 5'd7, 5'd8, 32'h0000_0003, m_n, m_w0, m_w1, m_e, m_li);
    run_req("b_odd", 3'd2, 7'h63, 3'd1, 5'd0, 5'd7, 5'd8, 32'h0000_0003, m_n, m_w0, m_w1, m_e, 0, g0, g1);
    model(3'd3, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h000F_FFFE, m_n, m_w0, m_w1, m_e, m_li);
    run_req("j_max", 3'd3, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h000F_FFFE, m_n, m_w0, m_w1, m_e, 0, g0, g1);
    model(3'd3, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0010_0000, m_n, m_w0, m_w1, m_e, m_li);
    run_req("j_over", 3'd3, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0010_0000, m_n, m_w0, m_w1, m_e, 0, g0, g1);

    // Reset while a request is in flight (between the two words when expansion is on).
    ImmSrc = 3'd0; opcode = 7'h13; funct3 = 3'd0; rd = 5'd5; rs1 = 5'd5; rs2 = 5'd0;
    imm = 32'h1234_5FFF; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("rst_mid.accepted", 32'(out_valid), 32'd1);
`ifdef IMM_ENCODER_LI_EXPAND_EN
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("rst_mid.word2_present", out_instr, 32'hFFF2_8293);
`endif
    reset = 1'b1;
    #1;
    check("rst_mid.out_valid", 32'(out_valid), 32'd0);
    check("rst_mid.out_instr", out_instr, 32'h0);
    check("rst_mid.range_err", 32'(range_err), 32'd0);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_mid.in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("rst_mid.quiet%0d", c), 32'(out_valid), 32'd0);
    end

    // Randomized requests checked against the model and the extend round trip.
    for (int t = 0; t < 40; t++) begin
      r_src = 3'($urandom_range(0, 7));
      r_op  = 7'($urandom);
      r_f3  = 3'($urandom);
      r_rd  = 5'($urandom);
      r_rs1 = 5'($urandom);
      r_rs2 = 5'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        r_src = 3'd0; r_op = 7'h13; r_f3 = 3'd0;
      end
      x = $urandom;
      case ($urandom_range(0, 3))
        0:       r_imm = x;
        1:       r_imm = {{19{x[12]}}, x[12:0]};
        2:       r_imm = {{11{x[20]}}, x[20:0]};
        default: r_imm = x & 32'hFFFF_F000;
      endcase
      if ($urandom_range(0, 1) == 1) r_imm[0] = 1'b0;
      model(r_src, r_op, r_f3, r_rd, r_rs1, r_rs2, r_imm, m_n, m_w0, m_w1, m_e, m_li);
      run_req($sformatf("rnd%0d", t), r_src, r_op, r_f3, r_rd, r_rs1, r_rs2, r_imm,
              m_n, m_w0, m_w1, m_e, $urandom_range(0, 2), g0, g1);
      if (!m_e) begin
        if (m_li) rebuilt = extend(g0, 3'd4) + ((m_n == 2) ? extend(g1, 3'd0) : 32'h0);
        else      rebuilt = extend(g0, r_src);
        check($sformatf("rnd%0d.round_trip", t), rebuilt, r_imm);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
